// File: rtl/chest_interp_pkg.sv
// ---------------------------------------------------------------------------
// chest_interp_pkg
// Shared definitions for the interpolation capture bank:
//   - state_t        : FSM state encoding (IDLE / CAPTURE / HOLD)
//   - sat_hi/sat_lo  : signed saturation bounds for a given register width
//   - width limits   : supported ranges for NUM_REG and REG_W
// ---------------------------------------------------------------------------
package chest_interp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_HOLD    = 2'd2
  } state_t;

  localparam int MIN_REG_W   = 8;
  localparam int MAX_REG_W   = 32;
  localparam int MAX_NUM_REG = 8;

  // Largest value representable in a w-bit two's-complement register.
  function automatic longint sat_hi(input int w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  // Smallest value representable in a w-bit two's-complement register.
  function automatic longint sat_lo(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage : chest_interp_pkg

// File: rtl/sat_conv.sv
// ---------------------------------------------------------------------------
// sat_conv
// Combinational signed width conversion from an ADD_W-bit adder result to a
// REG_W-bit stored term. Wider/equal targets sign-extend; narrower targets
// saturate to the signed range of REG_W and raise o_clip when clipping.
// Ports:
//   i_din  [ADD_W-1:0] signed input value
//   o_dout [REG_W-1:0] signed converted value
//   o_clip             1 when the input was outside the target range
// ---------------------------------------------------------------------------
module sat_conv
  import chest_interp_pkg::*;
#(
  parameter int ADD_W = 20,
  parameter int REG_W = 18
) (
  input  logic signed [ADD_W-1:0] i_din,
  output logic signed [REG_W-1:0] o_dout,
  output logic                    o_clip
);

  generate
    if (REG_W >= ADD_W) begin : g_extend
      // Size cast of a signed operand sign-extends.
      assign o_dout = REG_W'(i_din);
      assign o_clip = 1'b0;
    end else begin : g_saturate
      localparam logic signed [ADD_W-1:0] HI = ADD_W'(sat_hi(REG_W));
      localparam logic signed [ADD_W-1:0] LO = ADD_W'(sat_lo(REG_W));

      always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        o_dout = i_din[REG_W-1:0];
        o_clip = 1'b0;
        if (i_din > HI) begin
          o_dout = HI[REG_W-1:0];
          o_clip = 1'b1;
        end else if (i_din < LO) begin
          o_dout = LO[REG_W-1:0];
          o_clip = 1'b1;
        end
      end
    end
  endgenerate

endmodule : sat_conv

// File: rtl/interp_capture_bank.sv
// ---------------------------------------------------------------------------
// interp_capture_bank
// Captures NUM_REG signed interpolation terms, one per valid cycle, from one
// of two adder buses (chosen per register by SRC_MASK), converts each to
// REG_W bits and holds the complete frame until the consumer accepts it.
// Ports:
//   clk, rst            clock (rising edge), async active-low reset
//   start               begin a capture frame (honoured in IDLE / on handshake)
//   clear               synchronous abort: zero everything, back to IDLE
//   in_valid            adder results valid this cycle
//   adder1_res/2_res    signed source buses (ADD_W bits)
//   out_ready           consumer accepts the held frame
//   regs_out            register i at bits [i*REG_W +: REG_W]
//   out_valid           complete frame held
//   busy                high while capturing
//   sat_flag            sticky: a capture in this frame was clipped
// ---------------------------------------------------------------------------
module interp_capture_bank
  import chest_interp_pkg::*;
#(
  parameter int                 NUM_REG  = 3,
  parameter int                 ADD_W    = 20,
  parameter int                 REG_W    = 18,
  parameter logic [NUM_REG-1:0] SRC_MASK = NUM_REG'(3'b100)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       clear,
  input  logic                       in_valid,
  input  logic signed [ADD_W-1:0]    adder1_res,
  input  logic signed [ADD_W-1:0]    adder2_res,
  input  logic                       out_ready,
  output logic [NUM_REG*REG_W-1:0]   regs_out,
  output logic                       out_valid,
  output logic                       busy,
  output logic                       sat_flag
);

  localparam int                 IDX_W    = (NUM_REG > 1) ? $clog2(NUM_REG) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_REG - 1);

  state_t                   r_state;
  logic [IDX_W-1:0]         r_index;
  logic signed [REG_W-1:0]  r_regs [NUM_REG];
  logic                     r_out_valid;
  logic                     r_busy;
  logic                     r_sat;

  logic signed [REG_W-1:0]  w_conv1;
  logic signed [REG_W-1:0]  w_conv2;
  logic                     w_clip1;
  logic                     w_clip2;
  logic                     w_use_src2;
  logic signed [REG_W-1:0]  w_cap_val;
  logic                     w_cap_clip;

  sat_conv #(.ADD_W(ADD_W), .REG_W(REG_W)) u_conv1 (
    .i_din  (adder1_res),
    .o_dout (w_conv1),
    .o_clip (w_clip1)
  );

  sat_conv #(.ADD_W(ADD_W), .REG_W(REG_W)) u_conv2 (
    .i_din  (adder2_res),
    .o_dout (w_conv2),
    .o_clip (w_clip2)
  );

  // Source for the register currently being filled.
  assign w_use_src2 = SRC_MASK[r_index];
  assign w_cap_val  = w_use_src2 ? w_conv2 : w_conv1;
  assign w_cap_clip = w_use_src2 ? w_clip2 : w_clip1;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_index     <= '0;
      // NOTE: the term array is reset explicitly; a discarded frame must
      // never leak stale terms onto regs_out.
      for (int i = 0; i < NUM_REG; i++) r_regs[i] <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_sat       <= 1'b0;
    end else if (clear) begin
      // Abort outranks start, in_valid and the output handshake.
      r_state     <= ST_IDLE;
      r_index     <= '0;
      for (int i = 0; i < NUM_REG; i++) r_regs[i] <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_sat       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_CAPTURE;
            r_busy  <= 1'b1;
            r_index <= '0;
            r_sat   <= 1'b0;
          end
        end

        ST_CAPTURE: begin
          if (in_valid) begin
            r_regs[r_index] <= w_cap_val;
            if (w_cap_clip) r_sat <= 1'b1;
            if (r_index == LAST_IDX) begin
              r_state     <= ST_HOLD;
              r_out_valid <= 1'b1;
              r_busy      <= 1'b0;
              r_index     <= '0;
            end else begin
              r_index <= r_index + 1'b1;
            end
          end
        end

        ST_HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            // Start on the accepting cycle chains frames back to back.
            if (start) begin
              r_state <= ST_CAPTURE;
              r_busy  <= 1'b1;
              r_index <= '0;
              r_sat   <= 1'b0;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end

        default: begin
          r_state     <= ST_IDLE;
          r_index     <= '0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  generate
    for (genvar g = 0; g < NUM_REG; g++) begin : g_pack
      assign regs_out[g*REG_W +: REG_W] = r_regs[g];
    end
  endgenerate

  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign sat_flag  = r_sat;

endmodule : interp_capture_bank

// File: tb/tb_interp_capture_bank.sv
// ---------------------------------------------------------------------------
// tb_interp_capture_bank
// Directed bench for interp_capture_bank. Instance a uses the default
// parameters; instance b uses NUM_REG=5, REG_W=24, SRC_MASK=5'b10101.
// Inputs change 1 time unit after the rising edge; outputs are sampled at
// that same point, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_interp_capture_bank;

  logic clk = 1'b0;
  logic rst = 1'b0;

  // instance a (defaults)
  logic        start = 1'b0, clear = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [19:0] adder1 = '0, adder2 = '0;
  logic [53:0] regs_out;
  logic        out_valid, busy, sat_flag;

  // instance b (5 x 24-bit, mask 10101)
  logic         b_start = 1'b0, b_clear = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b0;
  logic [19:0]  b_adder1 = '0, b_adder2 = '0;
  logic [119:0] b_regs_out;
  logic         b_out_valid, b_busy, b_sat_flag;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  interp_capture_bank dut_a (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .clear      (clear),
    .in_valid   (in_valid),
    .adder1_res (adder1),
    .adder2_res (adder2),
    .out_ready  (out_ready),
    .regs_out   (regs_out),
    .out_valid  (out_valid),
    .busy       (busy),
    .sat_flag   (sat_flag)
  );

  interp_capture_bank #(
    .NUM_REG  (5),
    .ADD_W    (20),
    .REG_W    (24),
    .SRC_MASK (5'b10101)
  ) dut_b (
    .clk        (clk),
    .rst        (rst),
    .start      (b_start),
    .clear      (b_clear),
    .in_valid   (b_in_valid),
    .adder1_res (b_adder1),
    .adder2_res (b_adder2),
    .out_ready  (b_out_ready),
    .regs_out   (b_regs_out),
    .out_valid  (b_out_valid),
    .busy       (b_busy),
    .sat_flag   (b_sat_flag)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic cap(input logic [19:0] a1, input logic [19:0] a2);
    adder1   = a1;
    adder2   = a2;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic b_cap(input logic [19:0] a1, input logic [19:0] a2);
    b_adder1   = a1;
    b_adder2   = a2;
    b_in_valid = 1'b1;
    step();
    b_in_valid = 1'b0;
  endtask

  function automatic logic [17:0] a_reg(input int i);
    return regs_out[i*18 +: 18];
  endfunction

  function automatic logic [23:0] b_reg(input int i);
    return b_regs_out[i*24 +: 24];
  endfunction

  initial begin
    // ---------------- reset state ----------------
    step();
    step();
    check("rst_regs",      64'(regs_out), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy",      64'(busy), 64'd0);
    check("rst_sat",       64'(sat_flag), 64'd0);
    check("rst_b_regs",    64'(b_regs_out[63:0]), 64'd0);
    rst = 1'b1;
    step();

    // ---------------- basic frame, latency NUM_REG+1 ----------------
    adder1 = 20'h00100;
    adder2 = 20'h00203;
    do_start();
    check("f1_busy_after_start", 64'(busy), 64'd1);
    cap(20'h00100, 20'h00203);
    check("f1_ov_cap1", 64'(out_valid), 64'd0);
    cap(20'h00100, 20'h00203);
    check("f1_ov_cap2", 64'(out_valid), 64'd0);
    cap(20'h00100, 20'h00203);
    check("f1_ov_cap3",  64'(out_valid), 64'd1);
    check("f1_busy_hold", 64'(busy), 64'd0);
    check("f1_reg0", 64'(a_reg(0)), 64'h00100);
    check("f1_reg1", 64'(a_reg(1)), 64'h00100);
    check("f1_reg2", 64'(a_reg(2)), 64'h00203);
    check("f1_sat",  64'(sat_flag), 64'd0);
    handshake();
    check("f1_ov_after_hs",   64'(out_valid), 64'd0);
    check("f1_busy_after_hs", 64'(busy), 64'd0);

    // ---------------- saturation ----------------
    do_start();
    cap(20'h7FFFF, 20'h00000);
    check("sat_pos_reg0", 64'(a_reg(0)), 64'h1FFFF);
    check("sat_pos_flag", 64'(sat_flag), 64'd1);
    cap(20'h00005, 20'h00000);
    cap(20'h00000, 20'h00001);
    check("sat_pos_ov",     64'(out_valid), 64'd1);
    check("sat_pos_sticky", 64'(sat_flag), 64'd1);
    handshake();

    do_start();
    check("sat_cleared_on_start", 64'(sat_flag), 64'd0);
    cap(20'h80000, 20'h00000);
    check("sat_neg_reg0", 64'(a_reg(0)), 64'h20000);
    check("sat_neg_flag", 64'(sat_flag), 64'd1);
    cap(20'h00000, 20'h00000);
    cap(20'h00000, 20'h00000);
    handshake();

    do_start();
    cap(20'hFFFFF, 20'h00000);
    cap(20'hE0000, 20'h00000);
    cap(20'h00000, 20'h1FFFF);
    check("nosat_reg0",  64'(a_reg(0)), 64'h3FFFF);
    check("nosat_reg1",  64'(a_reg(1)), 64'h20000);
    check("nosat_reg2",  64'(a_reg(2)), 64'h1FFFF);
    check("nosat_flag",  64'(sat_flag), 64'd0);
    check("nosat_ov",    64'(out_valid), 64'd1);
    handshake();

    // ---------------- stall pattern 1,0,0,1,1 ----------------
    do_start();
    cap(20'h00011, 20'h00099);
    step();
    check("stall1_regs", 64'(regs_out), 64'({18'h1FFFF, 18'h20000, 18'h00011}));
    step();
    check("stall2_regs", 64'(regs_out), 64'({18'h1FFFF, 18'h20000, 18'h00011}));
    check("stall2_ov",   64'(out_valid), 64'd0);
    check("stall2_busy", 64'(busy), 64'd1);
    cap(20'h00022, 20'h00088);
    check("stall_cap2_ov", 64'(out_valid), 64'd0);
    cap(20'h00077, 20'h00033);
    check("stall_cap3_ov",   64'(out_valid), 64'd1);
    check("stall_cap3_regs", 64'(regs_out), 64'({18'h00033, 18'h00022, 18'h00011}));

    // ---------------- hold with out_ready low; start ignored ----------------
    start = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      check("hold_ov",   64'(out_valid), 64'd1);
      check("hold_regs", 64'(regs_out), 64'({18'h00033, 18'h00022, 18'h00011}));
      check("hold_busy", 64'(busy), 64'd0);
    end
    // back-to-back: handshake together with start
    out_ready = 1'b1;
    step();
    start     = 1'b0;
    out_ready = 1'b0;
    check("b2b_busy", 64'(busy), 64'd1);
    check("b2b_ov",   64'(out_valid), 64'd0);

    // ---------------- clear after two captures ----------------
    cap(20'h80000, 20'h00000);
    check("pre_clear_sat", 64'(sat_flag), 64'd1);
    cap(20'h00055, 20'h00000);
    check("pre_clear_reg1", 64'(a_reg(1)), 64'h00055);
    clear    = 1'b1;
    start    = 1'b1;
    in_valid = 1'b1;
    adder2   = 20'h00066;
    step();
    clear = 1'b0;
    start = 1'b0;
    check("clear_regs", 64'(regs_out), 64'd0);
    check("clear_busy", 64'(busy), 64'd0);
    check("clear_ov",   64'(out_valid), 64'd0);
    check("clear_sat",  64'(sat_flag), 64'd0);
    step();
    in_valid = 1'b0;
    check("idle_ignores_valid_regs", 64'(regs_out), 64'd0);
    check("idle_ignores_valid_busy", 64'(busy), 64'd0);

    // ---------------- async reset in HOLD ----------------
    do_start();
    cap(20'h00101, 20'h00000);
    cap(20'h00102, 20'h00000);
    cap(20'h00000, 20'h00103);
    check("pre_rst_ov", 64'(out_valid), 64'd1);
    rst = 1'b0;
    #1;
    check("async_rst_regs", 64'(regs_out), 64'd0);
    check("async_rst_ov",   64'(out_valid), 64'd0);
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_sat",  64'(sat_flag), 64'd0);
    #2;
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    step();
    step();
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("post_rst_ov",   64'(out_valid), 64'd0);
    check("post_rst_busy", 64'(busy), 64'd0);
    check("post_rst_regs", 64'(regs_out), 64'd0);
    do_start();
    cap(20'h00001, 20'h00000);
    cap(20'h00002, 20'h00000);
    cap(20'h00000, 20'h00003);
    check("resume_ov",   64'(out_valid), 64'd1);
    check("resume_regs", 64'(regs_out), 64'({18'h00003, 18'h00002, 18'h00001}));
    handshake();

    // ---------------- instance b: 5 regs, 24 bits, mask 10101 ----------------
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    check("b_busy", 64'(b_busy), 64'd1);
    b_cap(20'h80000, 20'h00001);
    b_cap(20'h80000, 20'h00009);
    b_cap(20'h00005, 20'h00003);
    b_cap(20'h7FFFF, 20'h00004);
    check("b_ov_cap4", 64'(b_out_valid), 64'd0);
    b_cap(20'h12345, 20'hFFFFE);
    check("b_ov_cap5", 64'(b_out_valid), 64'd1);
    check("b_reg0", 64'(b_reg(0)), 64'h000001);
    check("b_reg1", 64'(b_reg(1)), 64'hF80000);
    check("b_reg2", 64'(b_reg(2)), 64'h000003);
    check("b_reg3", 64'(b_reg(3)), 64'h07FFFF);
    check("b_reg4", 64'(b_reg(4)), 64'hFFFFFE);
    check("b_sat",  64'(b_sat_flag), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_interp_capture_bank
